// File: rtl/ook_pkg.sv
// Shared types and constants for the OOK receive path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ook_pkg;

  localparam int              ADC_W = 8;
  localparam logic [ADC_W-1:0] MID  = 8'd128;
  localparam int              ENV_W = 7;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  // Distance of an offset-binary sample from midscale, folded to 0..127.
  function automatic logic [ENV_W-1:0] rectify(input logic [ADC_W-1:0] s);
    logic [ADC_W-1:0] d;
    if (s >= MID) d = s - MID;
    else          d = 8'd127 - s;
    return d[ENV_W-1:0];
  endfunction

endpackage

// File: rtl/ook_envelope.sv
// Rectifier + leaky-integrator envelope detector + slicer producing the OOK line bit.
// Latency: adc sample -> acc next cycle -> carrier_det the cycle after.
// Backpressure: none; samples are taken only when adc_valid is high.
//
// Ports: clk, rst_n (sync active-low), adc_in[7:0] offset binary, adc_valid,
//        carrier_det (1 = carrier present).
// Build option: OOK_DEMOD_HYST_EN selects a two-threshold (hysteresis) slicer.
module ook_envelope
  import ook_pkg::*;
#(
  parameter int ENV_SHIFT = 4,
  parameter int THRESH_HI = 24,
  parameter int THRESH_LO = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ADC_W-1:0] adc_in,
  input  logic             adc_valid,
  output logic             carrier_det
);

  // Width chosen so the steady-state maximum (127 << ENV_SHIFT) just fits.
  localparam int ACC_W = ENV_W + ENV_SHIFT;

  localparam logic [ENV_W-1:0] HI = ENV_W'(THRESH_HI);

  logic [ENV_W-1:0] mag;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next;
  logic [ENV_W-1:0] env;

  assign mag = rectify(adc_in);

  // Decay first, then add: the intermediate never exceeds the steady maximum.
  assign acc_next = acc - (acc >> ENV_SHIFT) + ACC_W'(mag);

  // Top ENV_W bits of acc are exactly acc >> ENV_SHIFT.
  assign env = acc[ACC_W-1 -: ENV_W];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (adc_valid) begin
      acc <= acc_next;
    end
  end

`ifdef OOK_DEMOD_HYST_EN
  localparam logic [ENV_W-1:0] LO = ENV_W'(THRESH_LO);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      carrier_det <= 1'b0;
    end else if (!carrier_det && (env >= HI)) begin
      carrier_det <= 1'b1;
    end else if (carrier_det && (env < LO)) begin
      carrier_det <= 1'b0;
    end
  end
`else
  // Single-threshold slicer; the low threshold has no role here.
  logic unused_thresh_lo;
  assign unused_thresh_lo = ^THRESH_LO;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      carrier_det <= 1'b0;
    end else begin
      carrier_det <= (env >= HI);
    end
  end
`endif

endmodule

// File: rtl/ook_demod_rx.sv
// OOK receiver: envelope slicer feeding a UART-style 8N1 deframer with a one-byte output register.
// Latency: byte presented the cycle after the stop-bit sample (~9.5 bit times after start edge).
// Backpressure: byte_valid holds until byte_ready; a byte completing while full is dropped (overrun).
//
// Ports: clk, rst_n (sync active-low), adc_in[7:0], adc_valid, carrier_det,
//        byte_out[7:0]/byte_valid/byte_ready, frame_err and overrun (1-cycle pulses).
// Build option: OOK_DEMOD_HYST_EN (hysteresis slicer inside ook_envelope).
module ook_demod_rx
  import ook_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1042,
  parameter int ENV_SHIFT    = 4,
  parameter int THRESH_HI    = 24,
  parameter int THRESH_LO    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ADC_W-1:0] adc_in,
  input  logic             adc_valid,
  output logic             carrier_det,
  output logic [7:0]       byte_out,
  output logic             byte_valid,
  input  logic             byte_ready,
  output logic             frame_err,
  output logic             overrun
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  ook_envelope #(
    .ENV_SHIFT (ENV_SHIFT),
    .THRESH_HI (THRESH_HI),
    .THRESH_LO (THRESH_LO)
  ) u_env (
    .clk         (clk),
    .rst_n       (rst_n),
    .adc_in      (adc_in),
    .adc_valid   (adc_valid),
    .carrier_det (carrier_det)
  );

  rx_state_t        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_cnt, bit_cnt_n;
  logic [7:0]       shreg, shreg_n;
  logic             line_q;
  logic             deliver;
  logic             ferr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      line_q  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_cnt <= bit_cnt_n;
      shreg   <= shreg_n;
      line_q  <= carrier_det;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + 1'b1;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    deliver   = 1'b0;
    ferr      = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        // Start bit begins when the carrier drops out (mark -> space).
        if (line_q && !carrier_det) state_n = START;
      end
      START: begin
        // Re-check at mid start bit so short dropouts are ignored.
        if (cnt == HALF_LAST) begin
          cnt_n     = '0;
          bit_cnt_n = '0;
          state_n   = carrier_det ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n   = '0;
          shreg_n = {carrier_det, shreg[7:1]};
          if (bit_cnt == 3'd7) state_n = STOP;
          else                 bit_cnt_n = bit_cnt + 3'd1;
        end
      end
      STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n   = '0;
          deliver = carrier_det;
          ferr    = !carrier_det;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_out   <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= ferr;
      overrun   <= 1'b0;
      if (deliver) begin
        // A handshake in this same cycle frees the register for the new byte.
        if (byte_valid && !byte_ready) begin
          overrun <= 1'b1;
        end else begin
          byte_out   <= shreg;
          byte_valid <= 1'b1;
        end
      end else if (byte_valid && byte_ready) begin
        byte_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ook_demod_rx.sv
module tb_ook_demod_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] adc_in = 8'd128;
  logic       adc_valid = 1'b1;
  logic       carrier_det;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_ready = 1'b1;
  logic       frame_err;
  logic       overrun;

  int total = 0;
  int passed = 0;

  // Event counters, written only by the monitor below.
  int bv_cycles = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic [7:0] last_byte = 8'h00;

  bit tgl = 1'b0;

  localparam int BIT = 1042;

  ook_demod_rx dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .adc_in      (adc_in),
    .adc_valid   (adc_valid),
    .carrier_det (carrier_det),
    .byte_out    (byte_out),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .frame_err   (frame_err),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (byte_valid) begin
        bv_cycles++;
        last_byte = byte_out;
      end
      if (frame_err) fe_cnt++;
      if (overrun)   ov_cnt++;
    end
  end

  // Drive n clock cycles of carrier (full-scale 255/0) or idle (midscale).
  task automatic line_for(input bit on, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (on) begin
        adc_in = tgl ? 8'd255 : 8'd0;
        tgl = ~tgl;
      end else begin
        adc_in = 8'd128;
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_on);
    line_for(1'b0, BIT);
    for (int i = 0; i < 8; i++) line_for(b[i], BIT);
    line_for(stop_on, BIT);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    adc_in = 8'd128;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    adc_in = 8'd128;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({carrier_det, byte_valid, frame_err, overrun, byte_out} !== 12'h000)
      $display("FAIL reset_outputs: got %h expected 000",
               {carrier_det, byte_valid, frame_err, overrun, byte_out});
    else passed++;
    rst_n = 1'b1;
    line_for(1'b0, 40);
    total++;
    if (carrier_det !== 1'b0) $display("FAIL reset_idle_det: got %b expected 0", carrier_det);
    else passed++;
    total++;
    if (byte_valid !== 1'b0) $display("FAIL reset_idle_valid: got %b expected 0", byte_valid);
    else passed++;
  endtask

  task automatic test_carrier();
    int n;
    int fe0, bv0;
    n = 0;
    while (n < 30 && carrier_det !== 1'b1) begin
      line_for(1'b1, 1);
      n++;
    end
    total++;
    if (carrier_det !== 1'b1) $display("FAIL carrier_lock: got %b expected 1 within 30 samples", carrier_det);
    else passed++;
    line_for(1'b0, 100);
    total++;
    if (carrier_det !== 1'b0) $display("FAIL carrier_loss: got %b expected 0", carrier_det);
    else passed++;
    // The drop above launched a start-bit search; reset must abort it silently.
    fe0 = fe_cnt;
    bv0 = bv_cycles;
    do_reset();
    line_for(1'b1, 12000);
    total++;
    if (fe_cnt - fe0 !== 0) $display("FAIL reset_abort_ferr: got %0d pulses expected 0", fe_cnt - fe0);
    else passed++;
    total++;
    if (bv_cycles - bv0 !== 0) $display("FAIL reset_abort_valid: got %0d cycles expected 0", bv_cycles - bv0);
    else passed++;
  endtask

  task automatic test_frame_5a();
    int fe0, bv0, ov0;
    byte_ready = 1'b1;
    line_for(1'b1, 200);
    fe0 = fe_cnt; bv0 = bv_cycles; ov0 = ov_cnt;
    send_frame(8'h5A, 1'b1);
    line_for(1'b1, 300);
    total++;
    if (bv_cycles - bv0 !== 1) $display("FAIL frame5a_valid_cycles: got %0d expected 1", bv_cycles - bv0);
    else passed++;
    total++;
    if (last_byte !== 8'h5A) $display("FAIL frame5a_byte: got %h expected 5a", last_byte);
    else passed++;
    total++;
    if (fe_cnt - fe0 !== 0 || ov_cnt - ov0 !== 0)
      $display("FAIL frame5a_errs: got ferr=%0d ovr=%0d expected 0/0", fe_cnt - fe0, ov_cnt - ov0);
    else passed++;
    total++;
    if (byte_out !== 8'h5A || byte_valid !== 1'b0)
      $display("FAIL frame5a_after: got out=%h vld=%b expected 5a/0", byte_out, byte_valid);
    else passed++;
  endtask

  task automatic test_frame_err();
    int fe0, bv0;
    byte_ready = 1'b1;
    line_for(1'b1, 200);
    fe0 = fe_cnt; bv0 = bv_cycles;
    send_frame(8'h3C, 1'b0);
    line_for(1'b1, 300);
    total++;
    if (fe_cnt - fe0 !== 1) $display("FAIL ferr_pulses: got %0d expected 1", fe_cnt - fe0);
    else passed++;
    total++;
    if (bv_cycles - bv0 !== 0) $display("FAIL ferr_valid: got %0d cycles expected 0", bv_cycles - bv0);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int ov0, fe0;
    byte_ready = 1'b0;
    line_for(1'b1, 200);
    ov0 = ov_cnt; fe0 = fe_cnt;
    send_frame(8'h11, 1'b1);
    line_for(1'b1, 100);
    send_frame(8'h22, 1'b1);
    line_for(1'b1, 300);
    total++;
    if (byte_valid !== 1'b1 || byte_out !== 8'h11)
      $display("FAIL b2b_hold: got vld=%b out=%h expected 1/11", byte_valid, byte_out);
    else passed++;
    total++;
    if (ov_cnt - ov0 !== 1) $display("FAIL b2b_overrun: got %0d expected 1", ov_cnt - ov0);
    else passed++;
    total++;
    if (fe_cnt - fe0 !== 0) $display("FAIL b2b_ferr: got %0d expected 0", fe_cnt - fe0);
    else passed++;
    @(posedge clk);
    #1 byte_ready = 1'b1;
    @(posedge clk);
    #1 byte_ready = 1'b0;
    total++;
    if (byte_valid !== 1'b0) $display("FAIL b2b_drain: got vld=%b expected 0", byte_valid);
    else passed++;
    byte_ready = 1'b1;
  endtask

  task automatic test_dropout();
    int fe0, bv0;
    byte_ready = 1'b1;
    line_for(1'b1, 200);
    fe0 = fe_cnt; bv0 = bv_cycles;
    line_for(1'b0, 300);
    total++;
    if (carrier_det !== 1'b0) $display("FAIL dropout_seen: got %b expected 0", carrier_det);
    else passed++;
    line_for(1'b1, 1500);
    total++;
    if (fe_cnt - fe0 !== 0 || bv_cycles - bv0 !== 0)
      $display("FAIL dropout_abort: got ferr=%0d vld=%0d expected 0/0", fe_cnt - fe0, bv_cycles - bv0);
    else passed++;
    total++;
    if (carrier_det !== 1'b1) $display("FAIL dropout_relock: got %b expected 1", carrier_det);
    else passed++;
  endtask

`ifdef OOK_DEMOD_HYST_EN
  task automatic test_hyst();
    line_for(1'b1, 200);
    // Settle the envelope around 18..22 (between the two thresholds).
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #1 adc_in = ((i / 20) % 2 == 0) ? 8'd146 : 8'd150;
    end
    total++;
    if (carrier_det !== 1'b1) $display("FAIL hyst_hold: got %b expected 1", carrier_det);
    else passed++;
    line_for(1'b1, 200);
  endtask
`endif

  initial begin
    test_reset();
    test_carrier();
    test_frame_5a();
    test_frame_err();
    test_back_to_back();
    test_dropout();
`ifdef OOK_DEMOD_HYST_EN
    test_hyst();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
